// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the core (C) and debug (D) ports.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of C priority.
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int D_MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [1:0]        c_size_i,
  input  logic [31:0]       c_addr_i,
  input  logic [31:0]       c_wdata_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic              c_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic              d_err_o,
  output logic [31:0]       rdata_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_din_o,
  input  logic [31:0]       ram_dout_i
);

  typedef enum logic {IDLE, RD_PEND} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        c_g, d_g, any_g;
  logic        sel_we, mis, ld_go;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  logic        unused;

  assign unused = ^{c_addr_i[31:ADDR_W+2], d_addr_i[31:ADDR_W+2]};

  function automatic logic misal(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   misal = 1'b0;
      2'b01:   misal = a[0];
      2'b10:   misal = (a != 2'b00);
      default: misal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   byte_en = 4'b0001 << a;
      2'b01:   byte_en = 4'b0011 << a;
      default: byte_en = 4'b1111;
    endcase
  endfunction

`ifdef DMEM_ARB_RR_EN
  logic last_d;

  // round-robin: on conflict the port not granted last time wins
  always_comb begin
    c_g = rst_n_i & c_req_i & (~d_req_i | last_d);
    d_g = rst_n_i & d_req_i & (~c_req_i | ~last_d);
  end

  // remember who was granted last; D so that C wins the first conflict
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_d <= 1'b1;
    else if (c_g | d_g) last_d <= d_g;
  end
`else
  localparam int CW = $clog2(D_MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(D_MAX_WAIT);

  logic [CW-1:0] wait_q;
  logic          d_force;

  // C priority unless D has waited its maximum number of cycles
  always_comb begin
    d_force = d_req_i & (wait_q == WMAX);
    c_g = rst_n_i & c_req_i & ~d_force;
    d_g = rst_n_i & d_req_i & (~c_req_i | d_force);
  end

  // count consecutive denied D cycles, saturating
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wait_q <= '0;
    else if (!d_req_i || d_g) wait_q <= '0;
    else if (wait_q != WMAX) wait_q <= wait_q + 1'b1;
  end
`endif

  // steer the granted port onto the RAM and build byte enables
  always_comb begin
    any_g     = c_g | d_g;
    sel_we    = d_g ? d_we_i : c_we_i;
    sel_size  = d_g ? d_size_i : c_size_i;
    sel_addr  = d_g ? d_addr_i : c_addr_i;
    sel_wdata = d_g ? d_wdata_i : c_wdata_i;
    mis       = misal(sel_size, sel_addr[1:0]);
    ld_go     = any_g & ~mis & ~sel_we;
    c_gnt_o   = c_g;
    d_gnt_o   = d_g;
    c_err_o   = c_g & mis;
    d_err_o   = d_g & mis;
    ram_we_o  = '0;
    ram_addr_o = '0;
    ram_din_o = '0;
    if (any_g) begin
      ram_addr_o = sel_addr[ADDR_W+1:2];
      ram_din_o  = sel_wdata;
      if (sel_we && !mis) ram_we_o = byte_en(sel_size, sel_addr[1:0]);
    end
  end

  // read-pending state and owner of the outstanding read
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // next state and read-response steering
  always_comb begin
    state_d    = ld_go ? RD_PEND : IDLE;
    owner_d    = ld_go ? d_g : owner_q;
    c_rvalid_o = (state_q == RD_PEND) & ~owner_q;
    d_rvalid_o = (state_q == RD_PEND) & owner_q;
    rdata_o    = (state_q == RD_PEND) ? ram_dout_i : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant, byte enables, read return
// and starvation / round-robin behaviour of dmem_arbiter.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        c_req_i, c_we_i, d_req_i, d_we_i;
  logic [1:0]  c_size_i, d_size_i;
  logic [31:0] c_addr_i, c_wdata_i, d_addr_i, d_wdata_i;
  logic        c_gnt_o, c_rvalid_o, c_err_o;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] rdata_o, ram_din_o, ram_dout_i;
  logic [3:0]  ram_we_o;
  logic [15:0] ram_addr_o;

  int checks = 0;
  int failures = 0;

  dmem_arbiter dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_size_i(c_size_i),
    .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
    .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_err_o(c_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_err_o(d_err_o),
    .rdata_o(rdata_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_c(input logic req, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    c_req_i = req; c_we_i = we; c_size_i = sz; c_addr_i = a; c_wdata_i = wd;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    d_req_i = req; d_we_i = we; d_size_i = sz; d_addr_i = a; d_wdata_i = wd;
  endtask

  logic [1:0] exp_g;

  initial begin
    rst_n_i = 1'b0;
    ram_dout_i = 32'h0;
    drive_d(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_c(1'b1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    #3;
    chk("rst_c_gnt", {31'b0, c_gnt_o}, 32'h0);
    chk("rst_we", {28'b0, ram_we_o}, 32'h0);
    chk("rst_addr", {16'b0, ram_addr_o}, 32'h0);
    chk("rst_din", ram_din_o, 32'h0);
    chk("rst_rv", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h0);
    drive_c(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();
    rst_n_i = 1'b1;
    tick();

    // C word store
    drive_c(1'b1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    #1;
    chk("st_w_gnt", {30'b0, c_gnt_o, c_err_o}, 32'h2);
    chk("st_w_we", {28'b0, ram_we_o}, 32'hF);
    chk("st_w_addr", {16'b0, ram_addr_o}, 32'h4);
    chk("st_w_din", ram_din_o, 32'hDEADBEEF);
    tick();
    drive_c(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    chk("st_w_norv", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h0);
    tick();

    // C byte load at 0x13
    drive_c(1'b1, 1'b0, 2'b00, 32'h13, 32'h0);
    #1;
    chk("ld_b_gnt", {31'b0, c_gnt_o}, 32'h1);
    chk("ld_b_we", {28'b0, ram_we_o}, 32'h0);
    chk("ld_b_addr", {16'b0, ram_addr_o}, 32'h4);
    chk("ld_b_rv0", {31'b0, c_rvalid_o}, 32'h0);
    tick();
    drive_c(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    ram_dout_i = 32'h11223344;
    #1;
    chk("ld_b_rv1", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h2);
    chk("ld_b_data", rdata_o, 32'h11223344);
    tick();
    chk("ld_b_rv2", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h0);

    // half store at 0x2, byte store at 0x1
    drive_c(1'b1, 1'b1, 2'b01, 32'h2, 32'hAAAA0000);
    #1;
    chk("st_h_we", {28'b0, ram_we_o}, 32'hC);
    tick();
    drive_c(1'b1, 1'b1, 2'b00, 32'h1, 32'h0000BB00);
    #1;
    chk("st_b_we", {28'b0, ram_we_o}, 32'h2);
    tick();

    // misaligned word load at 0x6
    drive_c(1'b1, 1'b0, 2'b10, 32'h6, 32'h0);
    #1;
    chk("mis_w_gnt_err", {30'b0, c_gnt_o, c_err_o}, 32'h3);
    chk("mis_w_we", {28'b0, ram_we_o}, 32'h0);
    tick();
    drive_c(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    chk("mis_w_norv", {31'b0, c_rvalid_o}, 32'h0);
    tick();

    // size 11 load is misaligned, half store at odd address too
    drive_c(1'b1, 1'b0, 2'b11, 32'h0, 32'h0);
    #1;
    chk("mis_s3_err", {30'b0, c_gnt_o, c_err_o}, 32'h3);
    tick();
    drive_c(1'b1, 1'b1, 2'b01, 32'h5, 32'h0);
    #1;
    chk("mis_h_err_we", {27'b0, c_err_o, ram_we_o}, 32'h10);
    chk("mis_s3_norv", {31'b0, c_rvalid_o}, 32'h0);
    tick();
    drive_c(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

    // D alone half store at 0x8
    drive_d(1'b1, 1'b1, 2'b01, 32'h8, 32'h00001234);
    #1;
    chk("d_st_gnt", {30'b0, c_gnt_o, d_gnt_o}, 32'h1);
    chk("d_st_we", {28'b0, ram_we_o}, 32'h3);
    chk("d_st_addr", {16'b0, ram_addr_o}, 32'h2);
    chk("d_st_din", ram_din_o, 32'h00001234);
    tick();
    drive_d(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();

    // both ports request continuously
    drive_c(1'b1, 1'b1, 2'b10, 32'h0, 32'h1);
    drive_d(1'b1, 1'b1, 2'b10, 32'h4, 32'h2);
    for (int i = 0; i < 19; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_g = (i % 2 == 1) ? 2'b01 : 2'b10;
`else
      exp_g = (i % 9 == 8) ? 2'b01 : 2'b10;
`endif
      #1;
      chk($sformatf("arb_cyc%0d", i), {30'b0, c_gnt_o, d_gnt_o}, {30'b0, exp_g});
      tick();
    end
    drive_c(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_d(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    tick();

    // back-to-back loads C@0x0 then D@0x4
    drive_c(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
    #1;
    chk("b2b_c_gnt", {30'b0, c_gnt_o, d_gnt_o}, 32'h2);
    tick();
    drive_c(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive_d(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
    ram_dout_i = 32'hAAAA0000;
    #1;
    chk("b2b_d_gnt", {30'b0, c_gnt_o, d_gnt_o}, 32'h1);
    chk("b2b_d_addr", {16'b0, ram_addr_o}, 32'h1);
    chk("b2b_rv_c", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h2);
    chk("b2b_data_c", rdata_o, 32'hAAAA0000);
    tick();
    drive_d(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    ram_dout_i = 32'hBBBB1111;
    #1;
    chk("b2b_rv_d", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h1);
    chk("b2b_data_d", rdata_o, 32'hBBBB1111);
    tick();
    chk("b2b_rv_end", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h0);

    // reset while a read is pending
    drive_c(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    tick();
    ram_dout_i = 32'h55555555;
    #1;
    chk("rstp_rv_pre", {31'b0, c_rvalid_o}, 32'h1);
    rst_n_i = 1'b0;
    #1;
    chk("rstp_rv", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h0);
    chk("rstp_gnt", {30'b0, c_gnt_o, d_gnt_o}, 32'h0);
    chk("rstp_rdata", rdata_o, 32'h0);
    chk("rstp_addr", {16'b0, ram_addr_o}, 32'h0);
    tick();
    drive_c(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    rst_n_i = 1'b1;
    tick();
    chk("rstp_norv", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h0);
    tick();
    chk("rstp_norv2", {30'b0, c_rvalid_o, d_rvalid_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
